// File: rtl/aes128_round_sequencer_pkg.sv
// Shared AES-128 constants and the sequencer state encoding used by the
// round sequencer and its stream interface.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES128_ROUNDS = 10;
    localparam int RK_IDX_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/aes128_round_sequencer_if.sv
// Plaintext-in / ciphertext-out valid/ready stream between the ECB front end
// (master) and the round sequencer (slave).
interface aes128_round_sequencer_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_BLOCK_W-1:0] in_block;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_BLOCK_W-1:0] out_block;

    modport master (
        output in_valid, in_block, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, out_ready,
        output in_ready, out_valid, out_block
    );

endinterface

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryption controller: does the initial AddRoundKey itself,
// then steps an external single-cycle round datapath once per round.
module aes128_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    aes128_round_sequencer_if.slave stream,
    output logic [RK_IDX_W-1:0]    rk_idx,
    input  logic [AES_BLOCK_W-1:0] rk_in,
    output logic [AES_BLOCK_W-1:0] rnd_state,
    output logic                   rnd_final,
    input  logic [AES_BLOCK_W-1:0] rnd_result,
    output logic                   busy,
    output logic [CNT_W-1:0]       blk_count
);

    localparam logic [1:0] IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] ROUND = 2'(ST_ROUND);
    localparam logic [1:0] DONE  = 2'(ST_DONE);

    localparam logic [RK_IDX_W-1:0] LAST_RND = RK_IDX_W'(NUM_ROUNDS);

    logic [1:0]             state_q,     state_d;
    logic [RK_IDX_W-1:0]    round_ctr_q, round_ctr_d;
    logic [AES_BLOCK_W-1:0] state_reg_q, state_reg_d;
    logic [CNT_W-1:0]       blk_count_q, blk_count_d;

    always_comb begin
        state_d     = state_q;
        round_ctr_d = round_ctr_q;
        state_reg_d = state_reg_q;
        blk_count_d = blk_count_q;
        case (state_q)
            IDLE: begin
                // rk_idx is 0 here, so rk_in is the cipher key itself
                if (stream.in_valid) begin
                    state_reg_d = stream.in_block ^ rk_in;
                    round_ctr_d = RK_IDX_W'(1);
                    state_d     = ROUND;
                end
            end
            ROUND: begin
                state_reg_d = rnd_result;
                if (round_ctr_q == LAST_RND) begin
                    state_d = DONE;
                end else begin
                    round_ctr_d = round_ctr_q + RK_IDX_W'(1);
                end
            end
            DONE: begin
                if (stream.out_ready) begin
                    blk_count_d = blk_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            round_ctr_q <= '0;
            state_reg_q <= '0;
            blk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            round_ctr_q <= round_ctr_d;
            state_reg_q <= state_reg_d;
            blk_count_q <= blk_count_d;
        end
    end

    // in_ready is masked by reset so no block is taken while the FSM is being cleared
    assign stream.in_ready  = (state_q == IDLE) && !reset;
    assign stream.out_valid = (state_q == DONE);
    assign stream.out_block = state_reg_q;

    assign rk_idx    = (state_q == ROUND) ? round_ctr_q : '0;
    assign rnd_state = state_reg_q;
    assign rnd_final = (state_q == ROUND) && (round_ctr_q == LAST_RND);
    assign busy      = (state_q == ROUND) || (state_q == DONE);
    assign blk_count = blk_count_q;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Bench for aes128_round_sequencer: behavioural round datapath and key ROM,
// directed FIPS-197 vectors checked through an expected-result queue.
module tb_aes128_round_sequencer;

    logic clk;
    logic reset;

    aes128_round_sequencer_if sif ();
    aes128_round_sequencer_if sif2 ();

    logic [3:0]   rk_idx1, rk_idx2;
    logic [127:0] rk_in1, rk_in2;
    logic [127:0] rnd_state1, rnd_state2;
    logic         rnd_final1, rnd_final2;
    logic [127:0] rnd_result1, rnd_result2;
    logic [127:0] full1, fin1, full2, fin2;
    logic         busy1, busy2;
    logic [31:0]  blk_count1;
    logic [2:0]   blk_count2;

    logic [127:0] rk_rom [16];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int nblk   = 0;
    bit seen   = 0;

    typedef struct {
        logic [127:0] blk;
        int           acc_cyc;
    } sb_t;

    sb_t sb_q [$];
    sb_t exp_e;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_round_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stream     (sif.slave),
        .rk_idx     (rk_idx1),
        .rk_in      (rk_in1),
        .rnd_state  (rnd_state1),
        .rnd_final  (rnd_final1),
        .rnd_result (rnd_result1),
        .busy       (busy1),
        .blk_count  (blk_count1)
    );

    // narrow counter instance so the wrap from all-ones to zero is reachable
    aes128_round_sequencer #(.CNT_W(3)) dut_wrap (
        .clk        (clk),
        .reset      (reset),
        .stream     (sif2.slave),
        .rk_idx     (rk_idx2),
        .rk_in      (rk_in2),
        .rnd_state  (rnd_state2),
        .rnd_final  (rnd_final2),
        .rnd_result (rnd_result2),
        .busy       (busy2),
        .blk_count  (blk_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box from first principles: inverse as x^254, then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        logic [7:0] e;
        inv  = 8'h01;
        base = x;
        e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                b[rr+4*c] = a[rr + 4*((c+rr)%4)];
        if (last) begin
            a = b;
        end else begin
            for (int c = 0; c < 4; c++) begin
                a[4*c]   = xtime(b[4*c]) ^ xtime(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
                a[4*c+1] = b[4*c] ^ xtime(b[4*c+1]) ^ xtime(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
                a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xtime(b[4*c+2]) ^ xtime(b[4*c+3]) ^ b[4*c+3];
                a[4*c+3] = xtime(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xtime(b[4*c+3]);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i] ^ k[127-8*i -: 8];
        return r;
    endfunction

    assign rk_in1      = rk_rom[rk_idx1];
    assign full1       = aes_round(rnd_state1, rk_in1, 1'b0);
    assign fin1        = aes_round(rnd_state1, rk_in1, 1'b1);
    assign rnd_result1 = rnd_final1 ? fin1 : full1;

    assign rk_in2      = rk_rom[rk_idx2];
    assign full2       = aes_round(rnd_state2, rk_in2, 1'b0);
    assign fin2        = aes_round(rnd_state2, rk_in2, 1'b1);
    assign rnd_result2 = rnd_final2 ? fin2 : full2;

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_rom[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int r = 11; r < 16; r++) rk_rom[r] = '0;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Offers a block, records the accept cycle (cycle 0) and returns at cycle 1.
    task automatic send(input logic [127:0] pt, input logic [127:0] ct, input bit track,
                        output int waited);
        int n;
        n = 0;
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_block = pt;
        while (!sif.in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (!sif.in_ready) begin
            fail_note("accept_timeout", "no in_ready within 60 cycles, required accept");
            sif.in_valid = 1'b0;
        end else begin
            check("rk_idx_accept", 128'(rk_idx1), 128'(0));
            if (track) sb_q.push_back('{blk: ct, acc_cyc: cyc});
            $display("accept cycle %0d in=%h", cyc, pt);
            @(negedge clk);
            sif.in_valid = 1'b0;
        end
    endtask

    task automatic run_wrap(input int b);
        int n;
        n = 0;
        @(negedge clk);
        sif2.in_valid = 1'b1;
        sif2.in_block = '0;
        while (!sif2.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        sif2.in_valid = 1'b0;
        n = 0;
        while (!sif2.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!sif2.out_valid) begin
            fail_note("wrap_out_timeout", "no out_valid within 40 cycles");
        end else begin
            check("wrap_out_block", sif2.out_block, CT_Z);
        end
        @(negedge clk);
        check("wrap_count", 128'(blk_count2), 128'(b % 8));
        $display("wrap block %0d out=%h count=%0d", b, sif2.out_block, blk_count2);
    endtask

    // Scoreboard monitor: latency on first out_valid, block value on handshake.
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            seen = 1'b0;
        end else if (sif.out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb_q.size() == 0) fail_note("unexpected_output", "out_valid with no block expected");
                else check("latency", 128'(cyc - sb_q[0].acc_cyc), 128'(11));
            end
            if (sif.out_ready && sb_q.size() != 0) begin
                exp_e = sb_q.pop_front();
                check("out_block", sif.out_block, exp_e.blk);
                $display("deliver %0d cycle %0d out=%h", nblk, cyc, sif.out_block);
                nblk++;
                seen = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vcount;
        reset         = 1'b1;
        sif.in_valid  = 1'b0;
        sif.in_block  = '0;
        sif.out_ready = 1'b0;
        sif2.in_valid  = 1'b0;
        sif2.in_block  = '0;
        sif2.out_ready = 1'b0;
        load_key('0);

        repeat (3) @(negedge clk);
        check("rst_in_ready",  128'(sif.in_ready), 128'(0));
        check("rst_out_valid", 128'(sif.out_valid), 128'(0));
        check("rst_busy",      128'(busy1), 128'(0));
        check("rst_rnd_final", 128'(rnd_final1), 128'(0));
        check("rst_rk_idx",    128'(rk_idx1), 128'(0));
        check("rst_out_block", sif.out_block, 128'(0));
        check("rst_blk_count", 128'(blk_count1), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready",  128'(sif.in_ready), 128'(1));
        check("post_rst_out_valid", 128'(sif.out_valid), 128'(0));
        check("post_rst_busy",      128'(busy1), 128'(0));
        check("post_rst_out_block", sif.out_block, 128'(0));

        // C.1 vector with round-key index sequencing
        load_key(KEY_C);
        sif.out_ready = 1'b1;
        send(PT_C, CT_C, 1'b1, n);
        for (int i = 1; i <= 10; i++) begin
            check("rk_idx_seq",    128'(rk_idx1), 128'(i));
            check("rnd_final_seq", 128'(rnd_final1), 128'(i == 10));
            check("busy_round",    128'(busy1), 128'(1));
            if (i < 10) @(negedge clk);
        end
        @(negedge clk);
        check("done_out_valid", 128'(sif.out_valid), 128'(1));
        check("done_rk_idx",    128'(rk_idx1), 128'(0));
        check("done_rnd_final", 128'(rnd_final1), 128'(0));
        @(negedge clk);
        check("c1_blk_count", 128'(blk_count1), 128'(1));
        check("c1_in_ready",  128'(sif.in_ready), 128'(1));
        check("c1_busy",      128'(busy1), 128'(0));

        // Appendix B vector held in DONE for 20 cycles with a second block waiting
        load_key(KEY_B);
        sif.out_ready = 1'b0;
        send(PT_B, CT_B, 1'b1, n);
        repeat (10) @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_block = PT_B;
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid", 128'(sif.out_valid), 128'(1));
            check("bp_out_block", sif.out_block, CT_B);
            check("bp_in_ready",  128'(sif.in_ready), 128'(0));
            @(negedge clk);
        end
        sif.out_ready = 1'b1;
        send(PT_B, CT_B, 1'b1, n);
        check("bp_accept_delay", 128'(n), 128'(0));
        repeat (11) @(negedge clk);
        check("bp_blk_count", 128'(blk_count1), 128'(3));
        check("bp_in_ready_after", 128'(sif.in_ready), 128'(1));

        // reset during ROUND cycle 5 discards the block
        send(128'h0123456789abcdeffedcba9876543210, '0, 1'b0, n);
        repeat (4) @(negedge clk);
        check("abort_rk_idx_c5", 128'(rk_idx1), 128'(5));
        reset = 1'b1;
        @(negedge clk);
        check("abort_in_ready_rst", 128'(sif.in_ready), 128'(0));
        check("abort_busy_rst",     128'(busy1), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready",  128'(sif.in_ready), 128'(1));
        check("abort_busy",      128'(busy1), 128'(0));
        check("abort_blk_count", 128'(blk_count1), 128'(0));
        check("abort_out_block", sif.out_block, 128'(0));
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            if (sif.out_valid) vcount++;
            @(negedge clk);
        end
        check("abort_no_output", 128'(vcount), 128'(0));

        // counter wrap on the 3-bit instance: 7 -> 0 on the eighth block
        load_key('0);
        sif2.out_ready = 1'b1;
        check("wrap_start", 128'(blk_count2), 128'(0));
        for (int b = 1; b <= 8; b++) run_wrap(b);

        repeat (2) @(negedge clk);
        check("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
